ac_op_sequencer: RTL and testbench

Control-side driver for the accumulator datapath: accepts one AC instruction at a time over a valid/ready handshake, fetches the memory operand into DR when the instruction needs one, and then drives the 8-bit `ControlSig` word into the adder-and-logic unit for exactly one load cycle. It owns the E (extend/carry) flip-flop. It captures the adder carry or the shifted-out AC bit into E, and feeds E back to the datapath as `Eout_ff`. It sits between the instruction decoder and the adder-and-logic unit, and is the producer of the control interface that unit consumes.

---
 rtl/ac_op_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ac_op_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ac_op_sequencer.sv
// Accumulator control sequencer: accepts one AC instruction, fetches its memory
// operand when needed, pulses ControlSig for one EXEC cycle and owns the E flip-flop.
module ac_op_sequencer #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [3:0]    op_code,
  input  logic [AW-1:0] op_addr,
  output logic          op_done,
  output logic          op_err,
  output logic          mem_rd_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_rd_ack,
  input  logic          ac_lsb,
  input  logic          ac_msb,
  input  logic          Ein_ff,
  output logic          Eout_ff,
  output logic [7:0]    ControlSig
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_LDA = 4'd3;
  localparam logic [3:0] OP_CLA = 4'd4;
  localparam logic [3:0] OP_CMA = 4'd5;
  localparam logic [3:0] OP_CIR = 4'd6;
  localparam logic [3:0] OP_CIL = 4'd7;
  localparam logic [3:0] OP_CLE = 4'd8;
  localparam logic [3:0] OP_CME = 4'd9;
  localparam logic [3:0] OP_INP = 4'd10;

  // ControlSig bit positions consumed by the adder-and-logic unit
  localparam int B_AND = 0;
  localparam int B_ADD = 1;
  localparam int B_DR  = 2;
  localparam int B_INP = 3;
  localparam int B_COM = 4;
  localparam int B_SHR = 5;
  localparam int B_SHL = 6;
  localparam int B_LD  = 7;

  function automatic logic is_mem(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_ADD) || (op == OP_LDA);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_INP;
  endfunction

  // At most one function bit is ever set; CLA is LD alone, which clears AC.
  function automatic logic [7:0] ctrl_of(input logic [3:0] op);
    logic [7:0] c;
    c = 8'h00;
    case (op)
      OP_AND: begin c[B_LD] = 1'b1; c[B_AND] = 1'b1; end
      OP_ADD: begin c[B_LD] = 1'b1; c[B_ADD] = 1'b1; end
      OP_LDA: begin c[B_LD] = 1'b1; c[B_DR]  = 1'b1; end
      OP_INP: begin c[B_LD] = 1'b1; c[B_INP] = 1'b1; end
      OP_CMA: begin c[B_LD] = 1'b1; c[B_COM] = 1'b1; end
      OP_CIR: begin c[B_LD] = 1'b1; c[B_SHR] = 1'b1; end
      OP_CIL: begin c[B_LD] = 1'b1; c[B_SHL] = 1'b1; end
      OP_CLA: c[B_LD] = 1'b1;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          e_q, e_d;
  logic          op_ready_q, op_ready_d;
  logic          op_done_q, op_done_d;
  logic          op_err_q, op_err_d;
  logic          mem_rd_req_q, mem_rd_req_d;
  logic [7:0]    ctrl_q, ctrl_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mem_addr_d = mem_addr_q;
    e_d        = e_q;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          op_d = op_code;
          if (is_mem(op_code)) begin
            mem_addr_d = op_addr;
            state_d    = S_FETCH;
          end else if (is_legal(op_code)) begin
            state_d = S_EXEC;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (mem_rd_ack) state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_DONE;
        // E sees the pre-update AC bits, since AC loads on this same edge
        case (op_q)
          OP_ADD:  e_d = Ein_ff;
          OP_CIR:  e_d = ac_lsb;
          OP_CIL:  e_d = ac_msb;
          OP_CLE:  e_d = 1'b0;
          OP_CME:  e_d = ~e_q;
          default: e_d = e_q;
        endcase
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from next state so they leave the flops aligned with it
    op_ready_d   = (state_d == S_IDLE);
    mem_rd_req_d = (state_d == S_FETCH);
    op_done_d    = (state_d == S_DONE);
    op_err_d     = (state_d == S_DONE) && !is_legal(op_d);
    ctrl_d       = (state_d == S_EXEC) ? ctrl_of(op_d) : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      mem_addr_q   <= '0;
      e_q          <= 1'b0;
      op_ready_q   <= 1'b1;
      op_done_q    <= 1'b0;
      op_err_q     <= 1'b0;
      mem_rd_req_q <= 1'b0;
      ctrl_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      mem_addr_q   <= mem_addr_d;
      e_q          <= e_d;
      op_ready_q   <= op_ready_d;
      op_done_q    <= op_done_d;
      op_err_q     <= op_err_d;
      mem_rd_req_q <= mem_rd_req_d;
      ctrl_q       <= ctrl_d;
    end
  end

  assign op_ready   = op_ready_q;
  assign op_done    = op_done_q;
  assign op_err     = op_err_q;
  assign mem_rd_req = mem_rd_req_q;
  assign mem_addr   = mem_addr_q;
  assign Eout_ff    = e_q;
  assign ControlSig = ctrl_q;

endmodule

// File: tb/tb_ac_op_sequencer.sv
// Directed bench for ac_op_sequencer; each expected value is hand-derived from the
// cycle timing (accept edge 0, EXEC cycle 1 for non-memory ops, DONE one cycle later).
module tb_ac_op_sequencer;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          op_valid;
  logic          op_ready;
  logic [3:0]    op_code;
  logic [AW-1:0] op_addr;
  logic          op_done;
  logic          op_err;
  logic          mem_rd_req;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_ack;
  logic          ac_lsb;
  logic          ac_msb;
  logic          Ein_ff;
  logic          Eout_ff;
  logic [7:0]    ControlSig;

  int n_chk = 0;
  int n_err = 0;

  ac_op_sequencer #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_addr(op_addr), .op_done(op_done), .op_err(op_err),
    .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .mem_rd_ack(mem_rd_ack),
    .ac_lsb(ac_lsb), .ac_msb(ac_msb), .Ein_ff(Ein_ff), .Eout_ff(Eout_ff),
    .ControlSig(ControlSig)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [AW-1:0] addr);
    op_valid = 1'b1;
    op_code  = op;
    op_addr  = addr;
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_code = '0; op_addr = '0;
    mem_rd_ack = 1'b0; ac_lsb = 1'b0; ac_msb = 1'b0; Ein_ff = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", op_ready, 1);
    chk("rst_done", op_done, 0);
    chk("rst_err", op_err, 0);
    chk("rst_req", mem_rd_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_ctrl", ControlSig, 8'h00);
    chk("rst_e", Eout_ff, 0);

    // CME: E toggles 0 -> 1 on the EXEC edge
    issue(4'd9, '0);
    chk("cme_ctrl", ControlSig, 8'h00);
    chk("cme_ready", op_ready, 0);
    chk("cme_e_exec", Eout_ff, 0);
    chk("cme_done_c1", op_done, 0);
    tick();
    chk("cme_e", Eout_ff, 1);
    chk("cme_done", op_done, 1);
    chk("cme_err", op_err, 0);
    tick();
    chk("cme_ready_back", op_ready, 1);
    chk("cme_done_drop", op_done, 0);

    // CLE clears E so the ADD carry capture is observable
    issue(4'd8, '0);
    tick();
    chk("cle_e", Eout_ff, 0);
    tick();

    // ADD with ack on the third FETCH cycle and carry in during EXEC
    issue(4'd2, 12'h0A5);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("add_req_c%0d", i), mem_rd_req, 1);
      chk($sformatf("add_addr_c%0d", i), mem_addr, 12'h0A5);
      chk($sformatf("add_ctrl_c%0d", i), ControlSig, 8'h00);
      if (i == 3) mem_rd_ack = 1'b1;
      tick();
    end
    mem_rd_ack = 1'b0;
    Ein_ff = 1'b1;
    chk("add_req_drop", mem_rd_req, 0);
    chk("add_ctrl", ControlSig, 8'h82);
    chk("add_e_exec", Eout_ff, 0);
    tick();
    Ein_ff = 1'b0;
    chk("add_e", Eout_ff, 1);
    chk("add_done", op_done, 1);
    chk("add_ctrl_off", ControlSig, 8'h00);
    tick();
    chk("add_ready", op_ready, 1);

    // CIR/CIL capture: clear E, then CIR takes ac_lsb, CIL takes ac_msb
    issue(4'd8, '0); tick(); tick();
    ac_lsb = 1'b1;
    issue(4'd6, '0);
    chk("cir_ctrl", ControlSig, 8'hA0);
    tick();
    ac_lsb = 1'b0;
    chk("cir_e", Eout_ff, 1);
    tick();
    ac_msb = 1'b0;
    issue(4'd7, '0);
    chk("cil_ctrl", ControlSig, 8'hC0);
    tick();
    chk("cil_e0", Eout_ff, 0);
    tick();
    ac_msb = 1'b1;
    issue(4'd7, '0);
    tick();
    ac_msb = 1'b0;
    chk("cil_e1", Eout_ff, 1);
    tick();

    // Illegal opcode: straight to DONE with op_err, E kept
    issue(4'd13, '0);
    chk("ill_err", op_err, 1);
    chk("ill_done", op_done, 1);
    chk("ill_ctrl", ControlSig, 8'h00);
    chk("ill_e", Eout_ff, 1);
    chk("ill_ready", op_ready, 0);
    tick();
    chk("ill_err_drop", op_err, 0);
    chk("ill_done_drop", op_done, 0);
    chk("ill_ready_back", op_ready, 1);

    // Back-to-back: valid held, CMA then LDA; LDA waits for ready
    op_valid = 1'b1; op_code = 4'd5; op_addr = 12'h3C7;
    tick();
    op_code = 4'd3;
    chk("b2b_cma_ctrl", ControlSig, 8'h90);
    chk("b2b_ready_c1", op_ready, 0);
    tick();
    chk("b2b_ready_c2", op_ready, 0);
    chk("b2b_cma_done", op_done, 1);
    chk("b2b_req_c2", mem_rd_req, 0);
    tick();
    chk("b2b_ready_c3", op_ready, 1);
    tick();
    op_valid = 1'b0;
    chk("b2b_lda_req", mem_rd_req, 1);
    chk("b2b_lda_addr", mem_addr, 12'h3C7);
    chk("b2b_ready_c4", op_ready, 0);
    mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
    chk("b2b_lda_ctrl", ControlSig, 8'h84);
    tick();
    chk("b2b_lda_done", op_done, 1);
    chk("b2b_e_kept", Eout_ff, 1);
    mem_rd_ack = 1'b1;  // stray ack while idle must be ignored
    tick();
    chk("b2b_idle_ready", op_ready, 1);
    tick();
    mem_rd_ack = 1'b0;
    chk("b2b_no_dup_req", mem_rd_req, 0);
    chk("b2b_no_dup_ctrl", ControlSig, 8'h00);

    // Reset mid-FETCH with a coincident ack
    issue(4'd1, 12'h123);
    chk("rf_req_c1", mem_rd_req, 1);
    tick();
    rst = 1'b1; mem_rd_ack = 1'b1;
    tick();
    rst = 1'b0; mem_rd_ack = 1'b0;
    chk("rf_req", mem_rd_req, 0);
    chk("rf_ready", op_ready, 1);
    chk("rf_ctrl", ControlSig, 8'h00);
    chk("rf_e", Eout_ff, 0);
    chk("rf_addr", mem_addr, 0);
    tick();
    chk("rf_no_exec", ControlSig, 8'h00);
    chk("rf_no_done", op_done, 0);
    tick();
    chk("rf_no_done2", op_done, 0);
    chk("rf_ready2", op_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
